mul_sched: RTL

//  Shares one constant-multiply datapath (x1, x3, x7, x8 of an 8-bit operand) among N_REQ requesters.

---
 rtl/mul_sched_pkg.sv | 24 ++
 rtl/mul_sched_if.sv | 39 +++
 rtl/mul_sched_rr_arb.sv | 31 +++
 rtl/mul_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared definitions for mul_sched: op encodings, FSM states and per-op step count.
package mul_sched_pkg;

  localparam logic [1:0] OP_X1 = 2'b00;
  localparam logic [1:0] OP_X3 = 2'b01;
  localparam logic [1:0] OP_X7 = 2'b10;
  localparam logic [1:0] OP_X8 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift-add steps needed per op: x3 = x + 2x, x7 = x + 2x + 4x, x8 is a single shift.
  function automatic logic [1:0] op_cycles(input logic [1:0] op);
    case (op)
      OP_X3:   return 2'd2;
      OP_X7:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Request/grant and result handshake bundle for mul_sched.
// MUL_SCHED_STATS_EN adds the done_cnt completion counter to the bundle.
interface mul_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int OW    = 11,
  parameter int IW    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ*2-1:0]  req_op;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                out_valid;
  logic [OW-1:0]       out_data;
  logic [IW-1:0]       out_id;
  logic                out_ready;
`ifdef MUL_SCHED_STATS_EN
  logic [15:0]         done_cnt;

  modport master (
    output req, req_data, req_op, out_ready,
    input  grant, busy, out_valid, out_data, out_id, done_cnt
  );
  modport slave (
    input  req, req_data, req_op, out_ready,
    output grant, busy, out_valid, out_data, out_id, done_cnt
  );
`else
  modport master (
    output req, req_data, req_op, out_ready,
    input  grant, busy, out_valid, out_data, out_id
  );
  modport slave (
    input  req, req_data, req_op, out_ready,
    output grant, busy, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/mul_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module mul_sched_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    int cand;
    cand   = 0;
    idx_o  = '0;
    pick_o = '0;
    any_o  = |req_i;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % N_REQ;
      if (req_i[cand]) begin
        idx_o = cand[IW-1:0];
      end
    end
    if (any_o) begin
      pick_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one x1/x3/x7/x8 shift-add multiplier among N_REQ clients.
// Optional feature macro: MUL_SCHED_STATS_EN (saturating done_cnt of completed results).
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int OW    = 11
) (
  input  logic       clk,
  input  logic       rst,
  mul_sched_if.slave bus
);

  localparam int IW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    x_q, x_d;
  logic [1:0]       op_q, op_d;
  logic [IW-1:0]    id_q, id_d;
  logic [1:0]       step_q, step_d;
  logic [OW-1:0]    acc_q, acc_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             out_valid_q, out_valid_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]    out_id_q, out_id_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [OW-1:0]    x_ext;

  mul_sched_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign x_ext = OW'(x_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    op_d        = op_q;
    id_d        = id_q;
    step_d      = step_q;
    acc_d       = acc_q;
    grant_d     = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          x_d     = bus.req_data[pick_idx*DW +: DW];
          op_d    = bus.req_op[pick_idx*2 +: 2];
          id_d    = pick_idx;
          grant_d = pick;
          ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          step_d  = 2'd0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        case (step_q)
          2'd0:    acc_d = (op_q == OP_X8) ? (x_ext << 3) : x_ext;
          2'd1:    acc_d = acc_q + (x_ext << 1);
          default: acc_d = acc_q + (x_ext << 2);
        endcase
        step_d = step_q + 2'd1;
        // Result is published on the edge that completes the last step.
        if (step_q == op_cycles(op_q) - 2'd1) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
          out_id_d    = id_q;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      x_q         <= '0;
      op_q        <= OP_X1;
      id_q        <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      op_q        <= op_d;
      id_q        <= id_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

`ifdef MUL_SCHED_STATS_EN
  logic [15:0] done_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && (done_cnt_q != 16'hFFFF)) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign bus.done_cnt = done_cnt_q;
`endif

endmodule
